axi4_lite_rr_arbiter: RTL

- Shares one downstream AXI4-Lite port between NUM_PORTS upstream requesters, for example several scenario-driven master BFMs or DMA engines contending for one slave BFM or one register block.
- Write and read paths are arbitrated independently, each with its own round-robin pointer.
- One outstanding transaction per path.
- Data width is 32 bits; WSTRB is passed through unchanged.

---
 rtl/axi4_lite_rr_arbiter.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite downstream port among NUM_PORTS requesters.
// Optional per-port completion counters: define AXI4_LITE_RR_ARBITER_STATS_EN.
module axi4_lite_rr_arbiter #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned IDX_W     = $clog2(NUM_PORTS),
  localparam int unsigned ADDR_W   = 32,
  localparam int unsigned DATA_W   = 32,
  localparam int unsigned STRB_W   = 4,
  localparam int unsigned PROT_W   = 3,
  localparam int unsigned RESP_W   = 2,
  localparam int unsigned CNT_W    = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [NUM_PORTS*ADDR_W-1:0]   s_awaddr,
  input  logic [NUM_PORTS*PROT_W-1:0]   s_awprot,
  input  logic [NUM_PORTS-1:0]          s_awvalid,
  output logic [NUM_PORTS-1:0]          s_awready,
  input  logic [NUM_PORTS*DATA_W-1:0]   s_wdata,
  input  logic [NUM_PORTS*STRB_W-1:0]   s_wstrb,
  input  logic [NUM_PORTS-1:0]          s_wvalid,
  output logic [NUM_PORTS-1:0]          s_wready,
  output logic [NUM_PORTS*RESP_W-1:0]   s_bresp,
  output logic [NUM_PORTS-1:0]          s_bvalid,
  input  logic [NUM_PORTS-1:0]          s_bready,
  input  logic [NUM_PORTS*ADDR_W-1:0]   s_araddr,
  input  logic [NUM_PORTS*PROT_W-1:0]   s_arprot,
  input  logic [NUM_PORTS-1:0]          s_arvalid,
  output logic [NUM_PORTS-1:0]          s_arready,
  output logic [NUM_PORTS*DATA_W-1:0]   s_rdata,
  output logic [NUM_PORTS*RESP_W-1:0]   s_rresp,
  output logic [NUM_PORTS-1:0]          s_rvalid,
  input  logic [NUM_PORTS-1:0]          s_rready,
  output logic [ADDR_W-1:0]             m_awaddr,
  output logic [PROT_W-1:0]             m_awprot,
  output logic                          m_awvalid,
  input  logic                          m_awready,
  output logic [DATA_W-1:0]             m_wdata,
  output logic [STRB_W-1:0]             m_wstrb,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  input  logic [RESP_W-1:0]             m_bresp,
  input  logic                          m_bvalid,
  output logic                          m_bready,
  output logic [ADDR_W-1:0]             m_araddr,
  output logic [PROT_W-1:0]             m_arprot,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  input  logic [DATA_W-1:0]             m_rdata,
  input  logic [RESP_W-1:0]             m_rresp,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  output logic                          wr_busy,
  output logic                          rd_busy,
  output logic [IDX_W-1:0]              wr_grant,
  output logic [IDX_W-1:0]              rd_grant
`ifdef AXI4_LITE_RR_ARBITER_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [NUM_PORTS*CNT_W-1:0]    stat_wr_cnt,
  output logic [NUM_PORTS*CNT_W-1:0]    stat_rd_cnt
`endif
);

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_FWD  = 2'd1;
  localparam logic [1:0] WR_RESP = 2'd2;

  localparam logic [1:0] RD_IDLE = 2'd0;
  localparam logic [1:0] RD_ADDR = 2'd1;
  localparam logic [1:0] RD_DATA = 2'd2;

  // First requesting port at or after last+1, wrapping.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                               input logic [IDX_W-1:0]     last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int unsigned      idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = 32'(last) + 32'd1 + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && req[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  logic [1:0]       wr_state, wr_state_nxt;
  logic [IDX_W-1:0] wr_grant_nxt, last_wr, last_wr_nxt;
  logic             aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic             aw_hs, w_hs;

  logic [1:0]       rd_state, rd_state_nxt;
  logic [IDX_W-1:0] rd_grant_nxt, last_rd, last_rd_nxt;

  assign wr_busy = (wr_state != WR_IDLE);
  assign rd_busy = (rd_state != RD_IDLE);

  // Write path state
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_state <= WR_IDLE;
      wr_grant <= '0;
      last_wr  <= IDX_W'(NUM_PORTS - 1);
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      wr_state <= wr_state_nxt;
      wr_grant <= wr_grant_nxt;
      last_wr  <= last_wr_nxt;
      aw_done  <= aw_done_nxt;
      w_done   <= w_done_nxt;
    end
  end

  // Write path next state and routing; all outputs idle unless the granted channel is live
  always_comb begin
    wr_state_nxt = wr_state;
    wr_grant_nxt = wr_grant;
    last_wr_nxt  = last_wr;
    aw_done_nxt  = aw_done;
    w_done_nxt   = w_done;
    aw_hs        = 1'b0;
    w_hs         = 1'b0;
    m_awaddr     = '0;
    m_awprot     = '0;
    m_awvalid    = 1'b0;
    m_wdata      = '0;
    m_wstrb      = '0;
    m_wvalid     = 1'b0;
    m_bready     = 1'b0;
    s_awready    = '0;
    s_wready     = '0;
    s_bvalid     = '0;
    s_bresp      = '0;
    case (wr_state)
      WR_IDLE: begin
        if (|s_awvalid) begin
          wr_grant_nxt = rr_pick(s_awvalid, last_wr);
          last_wr_nxt  = wr_grant_nxt;
          aw_done_nxt  = 1'b0;
          w_done_nxt   = 1'b0;
          wr_state_nxt = WR_FWD;
        end
      end
      WR_FWD: begin
        m_awaddr            = s_awaddr[ADDR_W*wr_grant +: ADDR_W];
        m_awprot            = s_awprot[PROT_W*wr_grant +: PROT_W];
        m_awvalid           = s_awvalid[wr_grant] & ~aw_done;
        s_awready[wr_grant] = m_awready & ~aw_done;
        m_wdata             = s_wdata[DATA_W*wr_grant +: DATA_W];
        m_wstrb             = s_wstrb[STRB_W*wr_grant +: STRB_W];
        m_wvalid            = s_wvalid[wr_grant] & ~w_done;
        s_wready[wr_grant]  = m_wready & ~w_done;
        aw_hs               = m_awvalid & m_awready;
        w_hs                = m_wvalid & m_wready;
        if (aw_hs) aw_done_nxt = 1'b1;
        if (w_hs)  w_done_nxt  = 1'b1;
        if ((aw_done | aw_hs) && (w_done | w_hs)) wr_state_nxt = WR_RESP;
      end
      WR_RESP: begin
        m_bready                           = s_bready[wr_grant];
        s_bvalid[wr_grant]                 = m_bvalid;
        s_bresp[RESP_W*wr_grant +: RESP_W] = m_bresp;
        if (m_bvalid && s_bready[wr_grant]) wr_state_nxt = WR_IDLE;
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  // Read path state
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_state <= RD_IDLE;
      rd_grant <= '0;
      last_rd  <= IDX_W'(NUM_PORTS - 1);
    end else begin
      rd_state <= rd_state_nxt;
      rd_grant <= rd_grant_nxt;
      last_rd  <= last_rd_nxt;
    end
  end

  // Read path next state and routing
  always_comb begin
    rd_state_nxt = rd_state;
    rd_grant_nxt = rd_grant;
    last_rd_nxt  = last_rd;
    m_araddr     = '0;
    m_arprot     = '0;
    m_arvalid    = 1'b0;
    m_rready     = 1'b0;
    s_arready    = '0;
    s_rvalid     = '0;
    s_rdata      = '0;
    s_rresp      = '0;
    case (rd_state)
      RD_IDLE: begin
        if (|s_arvalid) begin
          rd_grant_nxt = rr_pick(s_arvalid, last_rd);
          last_rd_nxt  = rd_grant_nxt;
          rd_state_nxt = RD_ADDR;
        end
      end
      RD_ADDR: begin
        m_araddr            = s_araddr[ADDR_W*rd_grant +: ADDR_W];
        m_arprot            = s_arprot[PROT_W*rd_grant +: PROT_W];
        m_arvalid           = s_arvalid[rd_grant];
        s_arready[rd_grant] = m_arready;
        if (s_arvalid[rd_grant] && m_arready) rd_state_nxt = RD_DATA;
      end
      RD_DATA: begin
        m_rready                           = s_rready[rd_grant];
        s_rvalid[rd_grant]                 = m_rvalid;
        s_rdata[DATA_W*rd_grant +: DATA_W] = m_rdata;
        s_rresp[RESP_W*rd_grant +: RESP_W] = m_rresp;
        if (m_rvalid && s_rready[rd_grant]) rd_state_nxt = RD_IDLE;
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

`ifdef AXI4_LITE_RR_ARBITER_STATS_EN
  logic [NUM_PORTS-1:0] wr_cmp, rd_cmp;

  // One-hot completion strobes on the upstream B / R handshakes
  always_comb begin
    wr_cmp = '0;
    rd_cmp = '0;
    if (wr_state == WR_RESP && m_bvalid && s_bready[wr_grant]) wr_cmp[wr_grant] = 1'b1;
    if (rd_state == RD_DATA && m_rvalid && s_rready[rd_grant]) rd_cmp[rd_grant] = 1'b1;
  end

  // Saturating counters; clear wins over increment
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stat_wr_cnt <= '0;
      stat_rd_cnt <= '0;
    end else if (stat_clr) begin
      stat_wr_cnt <= '0;
      stat_rd_cnt <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        if (wr_cmp[k] && stat_wr_cnt[CNT_W*k +: CNT_W] != {CNT_W{1'b1}})
          stat_wr_cnt[CNT_W*k +: CNT_W] <= stat_wr_cnt[CNT_W*k +: CNT_W] + CNT_W'(1);
        if (rd_cmp[k] && stat_rd_cnt[CNT_W*k +: CNT_W] != {CNT_W{1'b1}})
          stat_rd_cnt[CNT_W*k +: CNT_W] <= stat_rd_cnt[CNT_W*k +: CNT_W] + CNT_W'(1);
      end
    end
  end
`endif

endmodule
